// File: rtl/plot_framebuffer.sv
// Plot-interface receiver backed by a WIDTH x HEIGHT x 3 framebuffer, with a
// full-screen clear engine and a raster read-out port using a valid/ready handshake.
module plot_framebuffer #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_x,
  input  logic [6:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  input  logic       clear_start,
  input  logic [2:0] clear_colour,
  input  logic       scan_start,
  output logic       busy,
  output logic       clear_done,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_colour,
  output logic       pix_last,
  output logic [7:0] drop_count
);

  localparam int unsigned Pixels = WIDTH * HEIGHT;
  localparam int unsigned AW     = 15;
  localparam logic [AW-1:0] LastAddr = AW'(Pixels - 1);
  localparam logic [7:0]    XLast    = 8'(WIDTH - 1);
  localparam logic [6:0]    YLast    = 7'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StClear, StScan} state_e;

  state_e state_q, state_d;

  logic          busy_q;
  logic          clear_done_q;
  logic [2:0]    clear_colour_q;
  logic [AW-1:0] clear_addr_q;
  logic [7:0]    drop_count_q;

  logic [AW-1:0] scan_addr_q;
  logic [7:0]    scan_x_q;
  logic [6:0]    scan_y_q;
  logic          issue_done_q;

  // Read stage: holds the memory output until the output register can take it.
  logic          rd_valid_q;
  logic [7:0]    rd_x_q;
  logic [6:0]    rd_y_q;
  logic [2:0]    rd_data_q;

  logic          pix_valid_q;
  logic [7:0]    pix_x_q;
  logic [6:0]    pix_y_q;
  logic [2:0]    pix_colour_q;
  logic          pix_last_q;

  logic [2:0]    mem [Pixels];

  logic          in_range;
  logic          plot_ok;
  logic          plot_drop;
  logic [AW-1:0] plot_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          out_ready;
  logic          rd_en;
  logic          scan_end;
  logic          clear_last;
  logic          go_clear;
  logic          go_scan;

  always_comb begin
    in_range   = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    plot_ok    = vga_plot && in_range && (state_q != StClear);
    plot_drop  = vga_plot && !in_range && (state_q != StClear);
    plot_addr  = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
    clear_last = (state_q == StClear) && (clear_addr_q == LastAddr);
    go_clear   = (state_q == StIdle) && clear_start;
    go_scan    = (state_q == StIdle) && !clear_start && scan_start;

    out_ready  = !pix_valid_q || pix_ready;
    rd_en      = (state_q == StScan) && !issue_done_q && (!rd_valid_q || out_ready);
    scan_end   = pix_valid_q && pix_ready && pix_last_q;

    wr_en   = 1'b0;
    wr_addr = plot_addr;
    wr_data = vga_colour;
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = clear_addr_q;
      wr_data = clear_colour_q;
    end else if (plot_ok) begin
      wr_en = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d = StClear;
        end else if (scan_start) begin
          state_d = StScan;
        end
      end
      StClear: if (clear_last) state_d = StIdle;
      StScan:  if (scan_end)   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Same-address plot and scan read in one cycle returns the pre-write data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[scan_addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      clear_done_q   <= 1'b0;
      clear_colour_q <= 3'd0;
      clear_addr_q   <= '0;
      drop_count_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != StIdle);
      clear_done_q <= clear_last;
      if (go_clear) begin
        clear_colour_q <= clear_colour;
        clear_addr_q   <= '0;
      end else if (state_q == StClear) begin
        clear_addr_q <= clear_last ? '0 : clear_addr_q + 1'b1;
      end
      if (plot_drop && (drop_count_q != 8'hFF)) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_addr_q  <= '0;
      scan_x_q     <= 8'd0;
      scan_y_q     <= 7'd0;
      issue_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_x_q       <= 8'd0;
      rd_y_q       <= 7'd0;
    end else begin
      if (go_scan) begin
        scan_addr_q  <= '0;
        scan_x_q     <= 8'd0;
        scan_y_q     <= 7'd0;
        issue_done_q <= 1'b0;
      end else if (rd_en) begin
        if (scan_addr_q == LastAddr) begin
          issue_done_q <= 1'b1;
          scan_addr_q  <= '0;
        end else begin
          scan_addr_q <= scan_addr_q + 1'b1;
        end
        if (scan_x_q == XLast) begin
          scan_x_q <= 8'd0;
          scan_y_q <= scan_y_q + 7'd1;
        end else begin
          scan_x_q <= scan_x_q + 8'd1;
        end
      end

      if (rd_en) begin
        rd_valid_q <= 1'b1;
        rd_x_q     <= scan_x_q;
        rd_y_q     <= scan_y_q;
      end else if (rd_valid_q && out_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q  <= 1'b0;
      pix_x_q      <= 8'd0;
      pix_y_q      <= 7'd0;
      pix_colour_q <= 3'd0;
      pix_last_q   <= 1'b0;
    end else if (out_ready) begin
      pix_valid_q <= rd_valid_q;
      pix_last_q  <= rd_valid_q && (rd_x_q == XLast) && (rd_y_q == YLast);
      if (rd_valid_q) begin
        pix_x_q      <= rd_x_q;
        pix_y_q      <= rd_y_q;
        pix_colour_q <= rd_data_q;
      end
    end
  end

  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign drop_count = drop_count_q;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_colour = pix_colour_q;
  assign pix_last   = pix_last_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Scoreboard bench for plot_framebuffer: a reference framebuffer model feeds expected
// raster pixels into a queue that is drained as the DUT hands pixels over.
module tb_plot_framebuffer;

  localparam int unsigned W    = 160;
  localparam int unsigned H    = 24;
  localparam int unsigned NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       clear_start;
  logic [2:0] clear_colour;
  logic       scan_start;
  logic       busy;
  logic       clear_done;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;
  logic       pix_last;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  plot_framebuffer #(
    .WIDTH (W),
    .HEIGHT(H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .clear_start (clear_start),
    .clear_colour(clear_colour),
    .scan_start  (scan_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_colour  (pix_colour),
    .pix_last    (pix_last),
    .drop_count  (drop_count)
  );

  int unsigned n_vec;
  int unsigned n_err;
  logic [2:0]  ref_mem [NPIX];
  int unsigned ref_drop;
  logic [18:0] sb [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_ctrl", 32'({busy, clear_done, pix_valid, pix_last}), 32'd0);
    check_eq("rst_pix", 32'({pix_x, pix_y, pix_colour}), 32'd0);
    check_eq("rst_drop", 32'(drop_count), 32'd0);
  endtask

  task automatic plot(input int unsigned x, input int unsigned y, input logic [2:0] c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = c;
    vga_plot   = 1'b1;
    tick();
    vga_plot = 1'b0;
    if (x < W && y < H) ref_mem[y * W + x] = c;
    else if (ref_drop < 255) ref_drop++;
  endtask

  // Optionally raises scan_start alongside the request and pokes both starts mid-clear.
  task automatic do_clear(input logic [2:0] c, input bit both, input bit disturb);
    int unsigned cyc;
    clear_colour = c;
    clear_start  = 1'b1;
    scan_start   = both;
    tick();
    clear_start  = 1'b0;
    scan_start   = 1'b0;
    clear_colour = ~c;
    cyc = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_eq("clear_busy", 32'(busy), 32'd1);
      if (disturb && cyc == 100) begin
        clear_start = 1'b1;
        scan_start  = 1'b1;
      end
      if (cyc == 101) begin
        clear_start = 1'b0;
        scan_start  = 1'b0;
      end
    end while (!clear_done && cyc < NPIX + 50);
    check_eq("clear_latency", cyc, NPIX);
    @(posedge clk);
    @(negedge clk);
    check_eq("clear_done_pulse", 32'({clear_done, busy}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("idle_after_clear", 32'({pix_valid, busy}), 32'd0);
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < NPIX; i++) ref_mem[i] = c;
  endtask

  task automatic do_scan(input bit rnd);
    int unsigned cyc;
    logic [18:0] w;
    logic [18:0] hold_w;
    bit          hold_v;
    bit          seen;
    for (int unsigned i = 0; i < NPIX; i++) begin
      sb.push_back({8'(i % W), 7'(i / W), ref_mem[i], 1'(i == NPIX - 1)});
    end
    pix_ready  = 1'b1;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    cyc    = 0;
    hold_v = 1'b0;
    hold_w = '0;
    seen   = 1'b0;
    while (sb.size() > 0 && cyc < 4 * NPIX + 50) begin
      @(posedge clk);
      #1;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      w = {pix_x, pix_y, pix_colour, pix_last};
      if (cyc == 1) check_eq("scan_busy", 32'(busy), 32'd1);
      if (pix_valid && !seen) begin
        seen = 1'b1;
        check_eq("scan_latency", cyc, 32'd2);
      end
      if (hold_v) check_eq("stall_hold", 32'({pix_valid, w}), 32'({1'b1, hold_w}));
      if (pix_valid && pix_ready) check_eq("pixel", 32'(w), 32'(sb.pop_front()));
      hold_v = pix_valid && !pix_ready;
      hold_w = w;
    end
    check_eq("scan_left", 32'(sb.size()), 32'd0);
    if (!rnd) check_eq("scan_cycles", cyc, NPIX + 1);
    pix_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("scan_end", 32'({pix_valid, busy}), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    ref_drop     = 0;
    rst_n        = 1'b0;
    vga_x        = 8'd0;
    vga_y        = 7'd0;
    vga_colour   = 3'd0;
    vga_plot     = 1'b0;
    clear_start  = 1'b0;
    clear_colour = 3'd0;
    scan_start   = 1'b0;
    pix_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Uniform clear followed by a full-speed scan.
    do_clear(3'b101, 1'b0, 1'b0);
    do_scan(1'b0);

    // Two in-range plots including the last pixel, plus out-of-range plots.
    do_clear(3'd0, 1'b0, 1'b0);
    plot(10, 20, 3'd3);
    plot(W - 1, H - 1, 3'd7);
    plot(W, 5, 3'd1);
    plot(3, H, 3'd2);
    plot(160, 5, 3'd4);
    plot(3, 120, 3'd5);
    check_eq("drop_count", 32'(drop_count), ref_drop);
    check_eq("pix_3210", 32'(ref_mem[3210]), 32'd3);
    do_scan(1'b0);

    // Randomly stalled consumer.
    plot(0, 0, 3'd6);
    plot(W - 1, 0, 3'd2);
    do_scan(1'b1);

    // Simultaneous requests favour clear; requests during clear are ignored.
    do_clear(3'd6, 1'b1, 1'b1);
    do_scan(1'b0);

    // Drop counter saturation.
    for (int k = 0; k < 300; k++) plot(200, 100, 3'd1);
    check_eq("drop_sat", 32'(drop_count), 32'd255);

    // Asynchronous reset mid-clear.
    clear_colour = 3'd4;
    clear_start  = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (2000) tick();
    check_eq("busy_pre_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs();
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n    = 1'b1;
    ref_drop = 0;
    tick();
    do_clear(3'd2, 1'b0, 1'b0);
    do_scan(1'b0);
    check_eq("drop_after_reset", 32'(drop_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
